// File: rtl/esp32_frame_pkg.sv
// Shared constants and types for the ESP32 UART TX framer.
package esp32_frame_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;
    localparam logic [7:0] CRC8_POLY   = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SOF     = 3'd1,
        ST_CMD     = 3'd2,
        ST_LEN     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CSUM    = 3'd5
    } state_e;

endpackage

// File: rtl/esp32_crc8.sv
// One-byte CRC-8 update (MSB first, no reflection), purely combinational.
module esp32_crc8
    import esp32_frame_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/esp32_tx_framer.sv
// Frames SOF/cmd/len/payload/checksum bytes toward a UART transmitter.
// Define ESP32_FRAMER_CRC8_EN to swap the XOR checksum for CRC-8.
module esp32_tx_framer
    import esp32_frame_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE = SOF_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       start_ready,
    input  logic [7:0] cmd,
    input  logic [7:0] len,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    input  logic       pl_last,
    output logic       pl_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       done,
    output logic       len_err
);

    state_e     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] csum_q, csum_d;
    logic       done_q, done_d;
    logic [7:0] csum_byte, csum_next;
    logic       tx_xfer;

    // Header bytes come from registers; payload is a zero-latency pass-through.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        pl_ready = 1'b0;
        case (state_q)
            ST_SOF:     begin tx_valid = 1'b1; tx_data = SOF_BYTE; end
            ST_CMD:     begin tx_valid = 1'b1; tx_data = cmd_q;    end
            ST_LEN:     begin tx_valid = 1'b1; tx_data = len_q;    end
            ST_PAYLOAD: begin
                tx_valid = pl_valid;
                tx_data  = pl_data;
                pl_ready = tx_ready;
            end
            ST_CSUM:    begin tx_valid = 1'b1; tx_data = csum_q;   end
            default:    ;
        endcase
    end

    assign tx_xfer     = tx_valid && tx_ready;
    assign start_ready = (state_q == ST_IDLE);
    assign done        = done_q;
    assign len_err     = (state_q == ST_PAYLOAD) && tx_xfer && (pl_last != (cnt_q == 8'd1));

    // cmd and len are folded in as they go out, so one update path covers every byte.
    always_comb begin
        case (state_q)
            ST_CMD:  csum_byte = cmd_q;
            ST_LEN:  csum_byte = len_q;
            default: csum_byte = pl_data;
        endcase
    end

`ifdef ESP32_FRAMER_CRC8_EN
    esp32_crc8 u_crc8 (
        .crc_in  (csum_q),
        .data_in (csum_byte),
        .crc_out (csum_next)
    );
`else
    assign csum_next = csum_q ^ csum_byte;
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_SOF;
                cmd_d   = cmd;
                len_d   = len;
                cnt_d   = len;
                csum_d  = 8'h00;
            end
            ST_SOF: if (tx_xfer) state_d = ST_CMD;
            ST_CMD: if (tx_xfer) begin
                state_d = ST_LEN;
                csum_d  = csum_next;
            end
            ST_LEN: if (tx_xfer) begin
                state_d = (len_q != 8'd0) ? ST_PAYLOAD : ST_CSUM;
                csum_d  = csum_next;
            end
            ST_PAYLOAD: if (tx_xfer) begin
                csum_d = csum_next;
                if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) state_d = ST_CSUM;
            end
            ST_CSUM: if (tx_xfer) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= 8'h00;
            len_q   <= 8'h00;
            cnt_q   <= 8'h00;
            csum_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: doc/esp32_tx_framer.md
ESP32_TX_FRAMER -- requirements
Module: esp32_tx_framer

Interface
REQ-001 SHALL have parameter SOF_BYTE, default 8'hA5, start-of-frame marker byte.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  frame request, qualified by start_ready.
REQ-005 SHALL have port start_ready  output  1  framer idle and able to accept start.
REQ-006 SHALL have port cmd  input  8  command byte, sampled when start && start_ready.
REQ-007 SHALL have port len  input  8  payload byte count (0-255), sampled with cmd.
REQ-008 SHALL have port pl_data  input  8  payload byte.
REQ-009 SHALL have port pl_valid  input  1  payload byte valid.
REQ-010 SHALL have port pl_last  input  1  producer marks final payload byte.
REQ-011 SHALL have port pl_ready  output  1  payload byte accepted this cycle when high with pl_valid.
REQ-012 SHALL have port tx_data  output  8  byte to the downstream UART transmitter.
REQ-013 SHALL have port tx_valid  output  1  tx_data valid.
REQ-014 SHALL have port tx_ready  input  1  UART transmitter ready; transfer when tx_valid && tx_ready.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the checksum byte transfers.
REQ-016 SHALL have port len_err  output  1  one-cycle pulse on payload/len mismatch.

Function
REQ-017 SHALL emit frames as SOF_BYTE, cmd, len, len payload bytes, checksum, in that order.
REQ-018 SHALL implement states IDLE, SOF, CMD, LEN, PAYLOAD, CSUM.
REQ-019 SHALL transition IDLE->SOF on start && start_ready, latching cmd and len and clearing the checksum.
REQ-020 SHALL transition SOF->CMD->LEN on each tx transfer; LEN->PAYLOAD if len!=0, else LEN->CSUM.
REQ-021 SHALL transition PAYLOAD->CSUM on transfer of the len-th payload byte, and CSUM->IDLE on checksum transfer.
REQ-022 SHALL assert start_ready only in IDLE; start in any other state is ignored.
REQ-023 SHALL pass payload through combinationally in PAYLOAD: tx_data=pl_data, tx_valid=pl_valid, pl_ready=tx_ready.
REQ-024 SHALL hold pl_ready low outside PAYLOAD.
REQ-025 SHALL hold tx_data stable and tx_valid high in SOF/CMD/LEN/CSUM until tx_ready.
REQ-026 SHALL hold tx_valid low in IDLE.
REQ-027 SHALL compute the checksum as the 8-bit XOR of cmd, len and every transferred payload byte.
REQ-028 SHALL use an 8-bit payload down-counter loaded with len; no wrap past zero.
REQ-029 SHALL pulse len_err when a payload byte transfers with pl_last != (counter==1); the frame length still follows len.
REQ-030 SHALL pulse done in the cycle after the CSUM transfer, with start_ready high in that same cycle.

Reset
REQ-031 SHALL, on rst_n low, immediately force IDLE, tx_valid=0, pl_ready=0, done=0, len_err=0, start_ready=1, tx_data=8'h00, checksum=0, counter=0.
REQ-032 SHALL abandon any partial frame on reset; no resume after reset release.

Configuration
REQ-033 SHALL, with ESP32_FRAMER_CRC8_EN defined, replace the XOR checksum with CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) over cmd, len, payload.
REQ-034 SHALL, without ESP32_FRAMER_CRC8_EN, use the XOR checksum and instantiate no CRC logic.

Structure
REQ-035 SHALL take the SOF default constant, the state enum type and the CRC polynomial constant from shared package esp32_frame_pkg.
REQ-036 SHALL place the CRC-8 byte update in sub-module esp32_crc8 (combinational next-CRC from crc_in and data_in), instantiated only under the macro.

Verification
REQ-037 SHALL cover: cmd=0x10, len=2, payload 01 02, tx_ready=1 -> tx bytes A5 10 02 01 02 11, then one done pulse.
REQ-038 SHALL cover: cmd=0x20, len=0 -> A5 20 00 20, pl_ready never high.
REQ-039 SHALL cover: tx_ready low 5 cycles while in CMD -> tx_data held at 0x10, tx_valid held high, no byte lost or duplicated.
REQ-040 SHALL cover: len=3 with pl_last on 2nd byte -> len_err pulse at that transfer, 3 payload bytes still sent.
REQ-041 SHALL cover: rst_n low mid-PAYLOAD -> tx_valid=0 the same cycle, IDLE after release; the next frame is correct.
REQ-042 SHALL cover: with ESP32_FRAMER_CRC8_EN, cmd=0x10, len=0 -> A5 10 00 57.
